// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC processing element: valid/ready operand intake, framed dot
// products, signed/unsigned beats, optional saturation and a held, handshaked result.
module systolic_mac_pe #(
    parameter int IN_WORD_SIZE  = 8,
    parameter int OUT_WORD_SIZE = 24,
    parameter bit SATURATE      = 1'b1
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WORD_SIZE-1:0]  a,
    input  logic [IN_WORD_SIZE-1:0]  b,
    input  logic                     sgn,
    input  logic                     first,
    input  logic                     last,
    output logic [IN_WORD_SIZE-1:0]  a_fwd,
    output logic [IN_WORD_SIZE-1:0]  b_fwd,
    output logic                     fwd_valid,
    output logic [OUT_WORD_SIZE-1:0] res,
    output logic                     res_ovf,
    output logic                     res_valid,
    input  logic                     res_ready
);
    localparam int PW = 2 * IN_WORD_SIZE;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                   state_reg, state_next;
    logic [OUT_WORD_SIZE-1:0] acc_reg, acc_next;
    logic                     ovf_acc_reg, ovf_acc_next;
    logic [IN_WORD_SIZE-1:0]  a_fwd_reg, b_fwd_reg;
    logic                     fwd_valid_reg;
    logic [OUT_WORD_SIZE-1:0] res_reg;
    logic                     res_ovf_reg, res_valid_reg;

    logic                     accept;
    logic [PW-1:0]            a_ext, b_ext, prod_raw;
    logic [OUT_WORD_SIZE-1:0] prod;
    logic [OUT_WORD_SIZE:0]   sum;
    logic                     sum_ovf;
    logic [OUT_WORD_SIZE-1:0] sat_val, acc_sum;
    logic [OUT_WORD_SIZE-1:0] final_acc;
    logic                     final_ovf;

    assign in_ready = !res_valid_reg || res_ready;
    assign accept   = in_valid && in_ready;

    // Extending both operands to 2N bits makes the low 2N product bits correct in either mode.
    assign a_ext    = {{IN_WORD_SIZE{sgn & a[IN_WORD_SIZE-1]}}, a};
    assign b_ext    = {{IN_WORD_SIZE{sgn & b[IN_WORD_SIZE-1]}}, b};
    assign prod_raw = a_ext * b_ext;

    generate
        if (OUT_WORD_SIZE > PW) begin : g_prod_ext
            assign prod = {{(OUT_WORD_SIZE-PW){sgn & prod_raw[PW-1]}}, prod_raw};
        end else begin : g_prod_flat
            assign prod = prod_raw[OUT_WORD_SIZE-1:0];
        end
    endgenerate

    assign sum = {sgn & acc_reg[OUT_WORD_SIZE-1], acc_reg}
               + {sgn & prod[OUT_WORD_SIZE-1], prod};
    assign sum_ovf = sgn ? (sum[OUT_WORD_SIZE] ^ sum[OUT_WORD_SIZE-1]) : sum[OUT_WORD_SIZE];

    // Signed overflow direction comes from the extended sign bit of the true sum.
    always_comb begin
        sat_val = '1;
        if (sgn) begin
            sat_val = sum[OUT_WORD_SIZE] ? {1'b1, {(OUT_WORD_SIZE-1){1'b0}}}
                                         : {1'b0, {(OUT_WORD_SIZE-1){1'b1}}};
        end
    end

    assign acc_sum = (sum_ovf && SATURATE) ? sat_val : sum[OUT_WORD_SIZE-1:0];

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        ovf_acc_next = ovf_acc_reg;
        final_acc    = prod;
        final_ovf    = 1'b0;
        if (accept) begin
            if (state_reg == ACC && !first) begin
                final_acc = acc_sum;
                final_ovf = ovf_acc_reg | sum_ovf;
            end
            if (last) begin
                acc_next     = '0;
                ovf_acc_next = 1'b0;
                state_next   = IDLE;
            end else begin
                acc_next     = final_acc;
                ovf_acc_next = final_ovf;
                state_next   = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ovf_acc_reg   <= 1'b0;
            a_fwd_reg     <= '0;
            b_fwd_reg     <= '0;
            fwd_valid_reg <= 1'b0;
            res_reg       <= '0;
            res_ovf_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ovf_acc_reg   <= ovf_acc_next;
            fwd_valid_reg <= accept;
            if (accept) begin
                a_fwd_reg <= a;
                b_fwd_reg <= b;
            end
            // A result completing in the same cycle the old one is read simply replaces it.
            if (accept && last) begin
                res_reg       <= final_acc;
                res_ovf_reg   <= final_ovf;
                res_valid_reg <= 1'b1;
            end else if (res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign a_fwd     = a_fwd_reg;
    assign b_fwd     = b_fwd_reg;
    assign fwd_valid = fwd_valid_reg;
    assign res       = res_reg;
    assign res_ovf   = res_ovf_reg;
    assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: saturating and wrapping instances share stimulus.
module tb_systolic_mac_pe;
    logic        clk = 1'b0;
    logic        clear_n;
    logic        in_valid, sgn, first, last, res_ready;
    logic [7:0]  a, b;
    logic        in_ready_s, fwd_valid_s, res_ovf_s, res_valid_s;
    logic        in_ready_w, fwd_valid_w, res_ovf_w, res_valid_w;
    logic [7:0]  a_fwd_s, b_fwd_s, a_fwd_w, b_fwd_w;
    logic [15:0] res_s, res_w;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    systolic_mac_pe #(.IN_WORD_SIZE(8), .OUT_WORD_SIZE(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .sgn(sgn), .first(first), .last(last),
        .a_fwd(a_fwd_s), .b_fwd(b_fwd_s), .fwd_valid(fwd_valid_s),
        .res(res_s), .res_ovf(res_ovf_s), .res_valid(res_valid_s), .res_ready(res_ready)
    );

    systolic_mac_pe #(.IN_WORD_SIZE(8), .OUT_WORD_SIZE(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .sgn(sgn), .first(first), .last(last),
        .a_fwd(a_fwd_w), .b_fwd(b_fwd_w), .fwd_valid(fwd_valid_w),
        .res(res_w), .res_ovf(res_ovf_w), .res_valid(res_valid_w), .res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one beat across the next rising edge.
    task automatic beat(input logic [7:0] ta, input logic [7:0] tbv,
                        input logic ts, input logic tf, input logic tl);
        a = ta; b = tbv; sgn = ts; first = tf; last = tl; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
        $display("beat a=%0d b=%0d sgn=%0d first=%0d last=%0d -> res=%0d/%0d ovf=%0d/%0d valid=%0d",
                 ta, tbv, ts, tf, tl, res_s, res_w, res_ovf_s, res_ovf_w, res_valid_s);
    endtask

    initial begin
        clear_n = 1'b0; in_valid = 1'b0; sgn = 1'b0; first = 1'b0; last = 1'b0;
        a = '0; b = '0; res_ready = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready_s), 32'd1);
        chk("rst_fwd_valid", 32'(fwd_valid_s), 32'd0);
        chk("rst_res_valid", 32'(res_valid_s), 32'd0);
        chk("rst_res", 32'(res_s), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Forwarding latency, then asynchronous reset in the middle of a sum
        beat(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
        chk("fwd_a", 32'(a_fwd_s), 32'd3);
        chk("fwd_b", 32'(b_fwd_s), 32'd5);
        chk("fwd_valid_hi", 32'(fwd_valid_s), 32'd1);
        @(negedge clk);
        chk("fwd_valid_lo", 32'(fwd_valid_s), 32'd0);
        chk("fwd_a_hold", 32'(a_fwd_s), 32'd3);
        beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst_a_fwd", 32'(a_fwd_s), 32'd0);
        chk("midrst_fwd_valid", 32'(fwd_valid_s), 32'd0);
        chk("midrst_res_valid", 32'(res_valid_s), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_s), 32'd1);
        @(negedge clk);
        clear_n = 1'b1;
        beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
        chk("post_rst_res", 32'(res_s), 32'd1);

        // Signed dot product: -12 + 14 + 1
        beat(8'hFD, 8'd4, 1'b1, 1'b1, 1'b0);
        beat(8'd7, 8'd2, 1'b1, 1'b0, 1'b0);
        beat(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        chk("sdot_res", 32'(res_s), 32'd3);
        chk("sdot_ovf", 32'(res_ovf_s), 32'd0);
        chk("sdot_valid", 32'(res_valid_s), 32'd1);
        chk("sdot_res_w", 32'(res_w), 32'd3);
        @(negedge clk);
        chk("sdot_valid_drop", 32'(res_valid_s), 32'd0);
        chk("sdot_res_hold", 32'(res_s), 32'd3);

        // Signed overflow: 3*16129 = 48387
        beat(8'd127, 8'd127, 1'b1, 1'b1, 1'b0);
        beat(8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
        beat(8'd127, 8'd127, 1'b1, 1'b0, 1'b1);
        chk("ssat_res", 32'(res_s), 32'd32767);
        chk("ssat_ovf", 32'(res_ovf_s), 32'd1);
        chk("swrap_res", 32'(res_w), 32'd48387);
        chk("swrap_ovf", 32'(res_ovf_w), 32'd1);

        // Unsigned overflow: 2*65025 = 130050
        beat(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        beat(8'd255, 8'd255, 1'b0, 1'b0, 1'b1);
        chk("usat_res", 32'(res_s), 32'd65535);
        chk("usat_ovf", 32'(res_ovf_s), 32'd1);
        chk("uwrap_res", 32'(res_w), 32'd64514);
        chk("uwrap_ovf", 32'(res_ovf_w), 32'd1);
        @(negedge clk);

        // Backpressure: held result blocks intake, then the stalled beat goes through
        res_ready = 1'b0;
        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
        chk("bp_res", 32'(res_s), 32'd6);
        chk("bp_ovf_cleared", 32'(res_ovf_s), 32'd0);
        chk("bp_valid", 32'(res_valid_s), 32'd1);
        #1;
        chk("bp_in_ready_lo", 32'(in_ready_s), 32'd0);
        a = 8'd4; b = 8'd5; sgn = 1'b0; first = 1'b1; last = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_stall_fwd_valid", 32'(fwd_valid_s), 32'd0);
            chk("bp_stall_a_fwd", 32'(a_fwd_s), 32'd2);
            chk("bp_stall_res_valid", 32'(res_valid_s), 32'd1);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_in_ready_hi", 32'(in_ready_s), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; first = 1'b0;
        $display("beat a=4 b=5 released after stall -> a_fwd=%0d valid=%0d", a_fwd_s, res_valid_s);
        chk("bp_resume_fwd_valid", 32'(fwd_valid_s), 32'd1);
        chk("bp_resume_a_fwd", 32'(a_fwd_s), 32'd4);
        chk("bp_resume_b_fwd", 32'(b_fwd_s), 32'd5);
        chk("bp_consumed", 32'(res_valid_s), 32'd0);
        chk("bp_res_hold", 32'(res_s), 32'd6);
        beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b1);
        chk("bp_sum", 32'(res_s), 32'd21);

        // Framing: a mid-sum first restarts; one-beat products back to back
        beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
        beat(8'd5, 8'd5, 1'b0, 1'b0, 1'b0);
        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        beat(8'd4, 8'd1, 1'b0, 1'b0, 1'b1);
        chk("frame_restart", 32'(res_s), 32'd10);
        beat(8'd6, 8'd7, 1'b0, 1'b1, 1'b1);
        chk("frame_single", 32'(res_s), 32'd42);
        chk("frame_single_valid", 32'(res_valid_s), 32'd1);
        beat(8'd2, 8'd2, 1'b0, 1'b1, 1'b1);
        chk("frame_replace", 32'(res_s), 32'd4);
        chk("frame_replace_valid", 32'(res_valid_s), 32'd1);
        beat(8'hFA, 8'd7, 1'b1, 1'b1, 1'b1);
        chk("frame_single_neg", 32'(res_s), 32'd65494);
        chk("frame_single_neg_ovf", 32'(res_ovf_s), 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
